// File: rtl/vend_pkg.sv
// Shared types and constants for the vending transaction sequencer.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        COLLECT  = 2'b01,
        DISPENSE = 2'b10,
        PAYOUT   = 2'b11
    } vend_state_t;

    localparam logic [1:0] COIN_1 = 2'b01;
    localparam logic [1:0] COIN_2 = 2'b10;

    localparam int CREDIT_W = 4;

endpackage

// File: rtl/vend_timeout.sv
// Loadable up-counter with clear and enable; tc flags the last idle cycle before a timeout.
module vend_timeout #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic        tc
);

    localparam logic [15:0] TERMINAL = 16'(TIMEOUT - 1);

    logic [15:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= count + 16'd1;
        end
    end

    assign tc = (count == TERMINAL);

endmodule

// File: rtl/vend_seq.sv
// Vending transaction sequencer: collects coins, requests a dispense, then
// refunds change or cancelled credit one unit coin at a time.
module vend_seq
    import vend_pkg::*;
#(
    parameter int PRICE   = 3,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_valid,
    input  logic [1:0]          coin_val,
    output logic                coin_ready,
    input  logic                cancel,
    output logic                disp_req,
    input  logic                disp_ack,
    output logic                pay_req,
    input  logic                pay_ack,
    output logic [CREDIT_W-1:0] credit,
    output logic                vend_done,
    output logic                busy
);

    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

    vend_state_t         state;
    vend_state_t         state_next;
    logic [CREDIT_W-1:0] credit_next;
    logic [CREDIT_W-1:0] credit_sum;
    logic                vend_done_next;
    logic                coin_accept;
    logic                timer_clr;
    logic                timer_tc;

    assign coin_ready  = (state == IDLE) || (state == COLLECT);
    assign disp_req    = (state == DISPENSE);
    assign pay_req     = (state == PAYOUT) && (credit != '0);
    assign busy        = (state == DISPENSE) || (state == PAYOUT);

    assign coin_accept = coin_valid && coin_ready &&
                         ((coin_val == COIN_1) || (coin_val == COIN_2));
    assign credit_sum  = credit + {2'b00, coin_val};

    // The idle timer only runs in COLLECT and restarts on every accepted coin.
    assign timer_clr   = coin_accept || (state != COLLECT);

    vend_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .clr      (timer_clr),
        .en       (state == COLLECT),
        .load     (1'b0),
        .load_val (16'd0),
        .tc       (timer_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            credit    <= '0;
            vend_done <= 1'b0;
        end else begin
            state     <= state_next;
            credit    <= credit_next;
            vend_done <= vend_done_next;
        end
    end

    always_comb begin
        state_next     = state;
        credit_next    = credit;
        vend_done_next = 1'b0;
        case (state)
            IDLE: begin
                if (coin_accept) begin
                    credit_next = credit_sum;
                    state_next  = (credit_sum >= PRICE_C) ? DISPENSE : COLLECT;
                end
            end
            COLLECT: begin
                // Reaching the price wins over a simultaneous cancel or timeout.
                if (coin_accept) begin
                    credit_next = credit_sum;
                end
                if (coin_accept && (credit_sum >= PRICE_C)) begin
                    state_next = DISPENSE;
                end else if (cancel || (timer_tc && !coin_accept)) begin
                    state_next = PAYOUT;
                end
            end
            DISPENSE: begin
                if (disp_ack) begin
                    credit_next    = credit - PRICE_C;
                    vend_done_next = 1'b1;
                    state_next     = (credit != PRICE_C) ? PAYOUT : IDLE;
                end
            end
            PAYOUT: begin
                if (credit == '0) begin
                    state_next = IDLE;
                end else if (pay_ack) begin
                    credit_next = credit - 1'b1;
                    if (credit == 4'd1) begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
